// File: rtl/instr_mem_sync.sv
// Fetch-side instruction memory: registered single-cycle fetch port with stall/flush,
// fault detection, byte-enabled program-load port and a post-reset NOP clear sequencer.
module instr_mem_sync #(
  parameter int unsigned ADDR_W      = 20,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter bit          CLR_ON_RST  = 1'b1,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           if_req,
  input  logic [ADDR_W-1:0]              if_addr,
  input  logic                           if_stall,
  input  logic                           if_flush,
  output logic [31:0]                    if_instr,
  output logic                           if_valid,
  output logic                           if_fault,
  input  logic                           ld_we,
  input  logic [$clog2(DEPTH_WORDS)-1:0] ld_waddr,
  input  logic [31:0]                    ld_wdata,
  input  logic [3:0]                     ld_be,
  output logic                           ready
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned IDX_W  = $clog2(DEPTH_WORDS);
  localparam int unsigned CNT_W  = IDX_W + 1;
  localparam int unsigned WA_W   = ADDR_W - 2;

  localparam logic [1:0] ST_RST   = 2'd0;
  localparam logic [1:0] ST_CLEAR = 2'd1;
  localparam logic [1:0] ST_READY = 2'd2;

  logic [DATA_W-1:0] r_mem [DEPTH_WORDS];

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_instr;
  logic              r_valid;
  logic              r_fault;
  logic              r_ready;

  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [DATA_W-1:0] w_instr_nxt;
  logic              w_valid_nxt;
  logic              w_fault_nxt;

  logic              w_mem_we;
  logic [IDX_W-1:0]  w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [BE_W-1:0]   w_mem_be;

  logic [WA_W-1:0]   w_word;
  logic [IDX_W-1:0]  w_idx;
  logic              w_misalign;
  logic              w_oor;
  logic [DATA_W-1:0] w_rdata;

  // Fetch address decode; the word index is only used when in range.
  assign w_word     = if_addr[ADDR_W-1:2];
  assign w_idx      = w_word[IDX_W-1:0];
  assign w_misalign = (if_addr[1:0] != 2'b00);
  assign w_oor      = ({1'b0, w_word} >= (WA_W+1)'(DEPTH_WORDS));
  assign w_rdata    = r_mem[w_idx];

  // Next-state, output and shared write-port selection.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_instr_nxt = NOP_INSTR;
    w_valid_nxt = 1'b0;
    w_fault_nxt = 1'b0;
    w_mem_we    = 1'b0;
    w_mem_addr  = ld_waddr;
    w_mem_wdata = ld_wdata;
    w_mem_be    = ld_be;

    case (r_state)
      ST_RST: begin
        w_cnt_nxt   = '0;
        w_state_nxt = CLR_ON_RST ? ST_CLEAR : ST_READY;
      end

      ST_CLEAR: begin
        if (r_cnt == CNT_W'(DEPTH_WORDS)) begin
          w_state_nxt = ST_READY;
        end else begin
          w_mem_we    = 1'b1;
          w_mem_addr  = r_cnt[IDX_W-1:0];
          w_mem_wdata = NOP_INSTR;
          w_mem_be    = {BE_W{1'b1}};
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end

      ST_READY: begin
        w_mem_we = ld_we && (ld_be != '0);
        if (if_flush) begin
          w_instr_nxt = NOP_INSTR;
        end else if (if_stall) begin
          w_instr_nxt = r_instr;
          w_valid_nxt = r_valid;
          w_fault_nxt = r_fault;
        end else if (if_req) begin
          w_valid_nxt = 1'b1;
          if (w_misalign || w_oor) begin
            w_fault_nxt = 1'b1;
          end else begin
            w_instr_nxt = w_rdata;
          end
        end
      end

      default: begin
        w_state_nxt = ST_RST;
      end
    endcase

    if (!rst_n) begin
      w_mem_we = 1'b0;
    end
  end

  // Control and output registers; the clear counter is deliberately not reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_RST;
      r_instr <= NOP_INSTR;
      r_valid <= 1'b0;
      r_fault <= 1'b0;
      r_ready <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_instr <= w_instr_nxt;
      r_valid <= w_valid_nxt;
      r_fault <= w_fault_nxt;
      r_ready <= (w_state_nxt == ST_READY);
    end
  end

  // Byte-enabled array write; the fetch read above sees the pre-edge contents.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      for (int k = 0; k < BE_W; k++) begin
        if (w_mem_be[k]) begin
          r_mem[w_mem_addr][8*k +: 8] <= w_mem_wdata[8*k +: 8];
        end
      end
    end
  end

  assign if_instr = r_instr;
  assign if_valid = r_valid;
  assign if_fault = r_fault;
  assign ready    = r_ready;

endmodule

// File: tb/tb_instr_mem_sync.sv
// Bench for instr_mem_sync: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against an edge-by-edge behavioural model.
module tb_instr_mem_sync;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DEPTH  = 16;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [7:0]  if_addr;
  logic        if_stall;
  logic        if_flush;
  logic [31:0] if_instr;
  logic        if_valid;
  logic        if_fault;
  logic        ld_we;
  logic [3:0]  ld_waddr;
  logic [31:0] ld_wdata;
  logic [3:0]  ld_be;
  logic        ready;

  int n_checks = 0;
  int n_err    = 0;

  instr_mem_sync #(
    .ADDR_W      (ADDR_W),
    .DEPTH_WORDS (DEPTH),
    .CLR_ON_RST  (1'b1),
    .NOP_INSTR   (NOP)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_stall (if_stall),
    .if_flush (if_flush),
    .if_instr (if_instr),
    .if_valid (if_valid),
    .if_fault (if_fault),
    .ld_we    (ld_we),
    .ld_waddr (ld_waddr),
    .ld_wdata (ld_wdata),
    .ld_be    (ld_be),
    .ready    (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: edges since reset release decide the clear/ready timeline.
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_instr;
  logic        m_valid;
  logic        m_fault;
  logic        m_ready;
  logic [31:0] m_mask;
  bit          m_init = 1'b0;
  bit          m_was_ready;
  int          m_rel = 0;
  int          m_w;

  always @(posedge clk) begin
    m_init = 1'b1;
    if (!rst_n) begin
      m_rel   = 0;
      m_ready = 1'b0;
      m_instr = NOP;
      m_valid = 1'b0;
      m_fault = 1'b0;
    end else begin
      m_was_ready = (m_rel >= DEPTH + 2);
      m_rel       = m_rel + 1;
      if (!m_was_ready) begin
        if (m_rel >= 2 && m_rel <= DEPTH + 1) m_mem[m_rel-2] = NOP;
        m_instr = NOP;
        m_valid = 1'b0;
        m_fault = 1'b0;
      end else begin
        if (if_flush) begin
          m_instr = NOP;
          m_valid = 1'b0;
          m_fault = 1'b0;
        end else if (!if_stall) begin
          m_w = int'(if_addr) / 4;
          if (!if_req) begin
            m_instr = NOP;
            m_valid = 1'b0;
            m_fault = 1'b0;
          end else if ((int'(if_addr) % 4) != 0 || m_w >= DEPTH) begin
            m_instr = NOP;
            m_valid = 1'b1;
            m_fault = 1'b1;
          end else begin
            m_instr = m_mem[m_w];
            m_valid = 1'b1;
            m_fault = 1'b0;
          end
        end
        if (ld_we) begin
          m_mask = {{8{ld_be[3]}}, {8{ld_be[2]}}, {8{ld_be[1]}}, {8{ld_be[0]}}};
          m_mem[ld_waddr] = (m_mem[ld_waddr] & ~m_mask) | (ld_wdata & m_mask);
        end
      end
      m_ready = (m_rel >= DEPTH + 2);
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (m_init)
      check("cycle", {29'b0, if_instr, if_valid, if_fault, ready},
                     {29'b0, m_instr, m_valid, m_fault, m_ready});
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fetch(input logic [7:0] a);
    if_req  = 1'b1;
    if_addr = a;
    step();
  endtask

  task automatic load(input logic [3:0] w, input logic [31:0] d, input logic [3:0] be);
    ld_we    = 1'b1;
    ld_waddr = w;
    ld_wdata = d;
    ld_be    = be;
    step();
    ld_we    = 1'b0;
  endtask

  task automatic check_out(input string name, input logic [31:0] ei, input logic ev, input logic ef);
    check(name, {30'b0, if_instr, if_valid, if_fault}, {30'b0, ei, ev, ef});
  endtask

  int k;

  initial begin
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_stall = 1'b0; if_flush = 1'b0;
    ld_we = 1'b0; ld_waddr = '0; ld_wdata = '0; ld_be = '0;
    repeat (3) @(negedge clk);
    check_out("reset_out", NOP, 1'b0, 1'b0);
    check("reset_ready", 64'(ready), 64'd0);

    // Interrupted clear: reset lands on the edge that would write word 7.
    rst_n = 1'b1; if_req = 1'b1; if_addr = '0;
    repeat (8) step();
    rst_n = 1'b0;
    step();
    check("midclr_ready", 64'(ready), 64'd0);

    // Full clear; a load pulse to an already-cleared word must be ignored.
    rst_n = 1'b1;
    k = 0;
    while (k < 40 && !ready) begin
      step();
      k++;
      if (k == 10) begin
        ld_we = 1'b1; ld_waddr = 4'd2; ld_wdata = 32'hDEAD_BEEF; ld_be = 4'hF;
      end else begin
        ld_we = 1'b0;
      end
    end
    ld_we = 1'b0;
    check("clear_edges", 64'(k), 64'(DEPTH + 2));
    check("clear_valid", 64'(if_valid), 64'd0);

    fetch(8'h00);
    check_out("post_clear_w0", NOP, 1'b1, 1'b0);
    fetch(8'h24);
    check_out("post_clear_w9", NOP, 1'b1, 1'b0);
    fetch(8'h08);
    check_out("ignored_ld_w2", NOP, 1'b1, 1'b0);

    if_req = 1'b0;
    load(4'd0, 32'h00A0_0213, 4'hF);
    fetch(8'h00);
    check_out("load_fetch", 32'h00A0_0213, 1'b1, 1'b0);

    if_req = 1'b0;
    load(4'd1, 32'h1122_3344, 4'hF);
    ld_we = 1'b1; ld_waddr = 4'd1; ld_wdata = 32'hAABB_CCDD; ld_be = 4'b0101;
    fetch(8'h04);
    ld_we = 1'b0;
    check_out("rbw_old", 32'h1122_3344, 1'b1, 1'b0);
    fetch(8'h04);
    check_out("rbw_new", 32'h11BB_33DD, 1'b1, 1'b0);

    fetch(8'h06);
    check_out("fault_misalign", NOP, 1'b1, 1'b1);
    fetch(8'h40);
    check_out("fault_range", NOP, 1'b1, 1'b1);
    fetch(8'h3C);
    check_out("last_word", NOP, 1'b1, 1'b0);

    fetch(8'h00);
    if_stall = 1'b1;
    if_addr  = 8'h04;
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("stall_hold", 32'h00A0_0213, 1'b1, 1'b0);
    end
    if_flush = 1'b1;
    step();
    check_out("stall_flush", NOP, 1'b0, 1'b0);
    if_flush = 1'b0;
    if_stall = 1'b0;

    // Randomized traffic, including occasional resets.
    for (int c = 0; c < 3000; c++) begin
      int kind;
      rst_n    = ($urandom_range(0, 499) != 0);
      if_req   = ($urandom_range(0, 3) != 0);
      kind     = $urandom_range(0, 7);
      if (kind == 0)      if_addr = 8'($urandom_range(0, 63) * 4 + $urandom_range(1, 3));
      else if (kind == 1) if_addr = 8'($urandom_range(16, 63) * 4);
      else                if_addr = 8'($urandom_range(0, 15) * 4);
      if_stall = ($urandom_range(0, 4) == 0);
      if_flush = ($urandom_range(0, 9) == 0);
      ld_we    = ($urandom_range(0, 2) == 0);
      ld_waddr = 4'($urandom_range(0, 15));
      ld_wdata = $urandom;
      ld_be    = 4'($urandom_range(0, 15));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/instr_mem_sync.md
# instr_mem_sync

Synchronous, parametrised instruction memory for the pipelined RV32I core; the next generation of the fetch-side memory. One fetch read port has one-cycle registered latency, with stall and flush controls, misalignment and range checking. A byte-enabled program-load write port lets a loader or testbench fill the image at run time. An optional post-reset clear sequencer fills the array with NOPs before fetch is allowed. The block sits between the IF-stage PC register and the IF/ID pipeline register.

## Interface
- `ADDR_W`, 20: fetch byte-address width.
- `DEPTH_WORDS`, 1024: number of 32-bit words; power of two, at most 2^(ADDR_W-2).
- `CLR_ON_RST`, 1: 1 runs the clear sequencer after reset; 0 makes the block ready immediately.
- `NOP_INSTR`, 32'h0000_0013: pattern used for clear fill and bubbles (ADDI x0,x0,0).

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  **synchronous, active-low reset**.
- `if_req`  in  1  fetch request.
- `if_addr`  in  ADDR_W  fetch byte address.
- `if_stall`  in  1  hold the output registers.
- `if_flush`  in  1  kill the output (bubble).
- `if_instr`  out  32  fetched instruction, registered.
- `if_valid`  out  1  `if_instr` is a real fetch.
- `if_fault`  out  1  misaligned or out-of-range fetch, registered.
- `ld_we`  in  1  load-port write strobe.
- `ld_waddr`  in  log2(DEPTH_WORDS)  word address.
- `ld_wdata`  in  32  write data, little-endian.
- `ld_be`  in  4  byte enables; bit k writes `ld_wdata[8k+7:8k]`.
- `ready`  out  1  clear sequence finished; fetch and load are accepted.

## Operation
- Storage is DEPTH_WORDS × 32. The byte at address 4w+k is bits [8k+7:8k] of word w, giving the same little-endian view as the previous generation.
- Array contents are not reset. Only the control registers and outputs reset.
- Clear FSM states:
  - RST: entered while `rst_n`=0.
  - CLEAR: entered on the first edge with `rst_n`=1 when CLR_ON_RST=1. Writes NOP_INSTR to word `clr_cnt` each cycle, with `clr_cnt` running 0..DEPTH_WORDS-1, then goes to READY.
  - READY: entered directly from RST when CLR_ON_RST=0.
- `ready` is 1 only in READY.
- Outside READY, `if_req` and `ld_we` are ignored: no write, and the output registers load a bubble.
- Fetch decode, in READY, on a clock edge where `if_stall`=0 and `if_flush`=0:
  - `if_req`=0 gives a bubble.
  - `if_req`=1 with `if_addr[1:0]`≠0, or with `if_addr[ADDR_W-1:2]` ≥ DEPTH_WORDS: `if_instr`=NOP_INSTR, `if_valid`=1, `if_fault`=1.
  - Otherwise `if_instr`=mem[`if_addr[ADDR_W-1:2]`], `if_valid`=1, `if_fault`=0.
- Bubble means `if_instr`=NOP_INSTR, `if_valid`=0, `if_fault`=0.
- Priority: reset > flush > stall > fetch.
  - Flush loads a bubble even while stalled.
  - Stall holds all three outputs unchanged and ignores `if_req`.
- Load port, in READY with `ld_we`=1: writes the enabled bytes of word `ld_waddr` at the edge. `ld_be`=0 is a no-op. A load write is independent of stall and flush.
- Same-cycle fetch and load to the same word is read-before-write: the fetch returns the old word, and the new value is visible to the next fetch.

## Timing
- Fetch latency is 1 cycle. A request sampled at edge N drives `if_instr`, `if_valid` and `if_fault` from just after edge N until the next update.
- Throughput is one fetch per cycle; there is no back-pressure beyond `if_stall`.
- Output reset values: `if_instr`=NOP_INSTR, `if_valid`=0, `if_fault`=0, `ready`=0 (1 after the first edge with `rst_n`=1 when CLR_ON_RST=0).
- Clear duration: `ready` rises DEPTH_WORDS+1 edges after the edge at which `rst_n` is first sampled high.
- Asserting `rst_n`=0 mid-clear or mid-operation returns to RST on that edge. Clearing restarts from word 0, and `clr_cnt` is not reset-held.
- Load writes complete at the edge; the written data is readable by a fetch sampled at the following edge.

## Test plan
- Reset/clear, DEPTH_WORDS=16, CLR_ON_RST=1: release `rst_n`, hold `if_req`=1 → `if_valid`=0 for 17 edges. Then `ready`=1, and fetching any word returns 0x00000013 with `if_valid`=1.
- Load then fetch: write 0x00A00213 to word 0 with `ld_be`=4'hF, then fetch 0x0 → next cycle `if_instr`=0x00A00213, `if_valid`=1, `if_fault`=0.
- Byte enables and read-before-write: word 1 = 0x11223344; write 0xAABBCCDD with `ld_be`=4'b0101 while fetching 0x4 in the same cycle → returns 0x11223344. Next fetch of 0x4 returns 0x11BB33DD.
- Faults:
  - Fetch 0x6 → `if_instr`=0x00000013, `if_valid`=1, `if_fault`=1.
  - Fetch 0x40 with DEPTH_WORDS=16 → `if_fault`=1.
- Stall/flush: fetch 0x0, then assert `if_stall` for 3 cycles while `if_addr`=0x4 → output holds the word-0 result. Then assert `if_stall`=1 and `if_flush`=1 together → `if_valid`=0 and `if_instr`=NOP_INSTR on the next cycle.
- Mid-clear reset: pull `rst_n` low at clear word 7, then release → `ready` rises 17 edges after release, and a `ld_we` pulse during clear leaves its target word equal to NOP_INSTR.
